imem_load_receiver: RTL
=======================

// Module: imem_load_receiver
// PURPOSE
// - Receiving end of the instruction-loader write stream (imem_we/imem_addr/imem_wdata/done).
// - Validates each write, SEC-DED encodes the word, buffers it, and drives the IMEM array write port.
// - Holds the CPU in its load phase until every accepted word has committed to the array.
// - Sits between instr_loader and the ECC-protected IMEM inside Pipeline_top.
// PARAMETERS
// - ADDR_W      32   loader byte-address width
// - DEPTH       256  IMEM depth in 32-bit words (power of two); IDX_W = $clog2(DEPTH)
// - FIFO_DEPTH  4    encoded-write buffer entries (power of two, >=2)
// PORTS
// - clk            in   1       system clock, rising edge
// - rst            in   1       asynchronous, active-low reset (0 = reset)
// - imem_we        in   1       loader write strobe; one word per cycle; no backpressure
// - imem_addr      in   ADDR_W  loader byte address
// - imem_wdata     in   32      instruction word
// - loader_done    in   1       level; high once the loader has issued its last write
// - mem_wready     in   1       array accepts a write this cycle; low while the array scrubs
// - mem_we         out  1       array write strobe; equals FIFO not-empty
// - mem_widx       out  IDX_W   word index of the FIFO head
// - mem_wcode      out  39      SEC-DED codeword of the FIFO head
// - cpu_release    out  1       load complete; CPU may fetch
// - words_written  out  16      count of words committed to the array (saturates at 16'hFFFF)
// - addr_err       out  1       sticky: a misaligned or out-of-range write was dropped
// - ovf_err        out  1       sticky: a write arrived while the FIFO was full and was dropped
// BEHAVIOUR
// - Reset (rst=0, any time, including mid-load): FIFO emptied; FSM=IDLE; all outputs 0.
// - Accept check: write is valid iff imem_we=1, imem_addr[1:0]=0, and imem_addr[ADDR_W-1:2] < DEPTH.
// - Invalid write: dropped; addr_err set; holds until reset.
// - Push: encoded {idx, code} enters the FIFO at the clock edge ending the write cycle N.
//   mem_we is high from cycle N+1 (1-cycle latency).
// - Pop: occurs when mem_we & mem_wready; words_written increments on each pop.
// - Full FIFO: a valid write is accepted if a pop happens in the same cycle.
//   Otherwise it is dropped and ovf_err is set (sticky).
// - Empty FIFO: a simultaneous push and pop never occurs, because output is registered.
// - FIFO pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
// - Encoding (combinational, before the push): Hamming(38,32) plus overall parity.
//   Codeword positions 1..38: parity bits at positions 1, 2, 4, 8, 16, 32.
//   Data bits d0..d31 fill the remaining positions in ascending order.
//   Bit 0 = XOR of bits 38:1, so the codeword has even overall parity.
// - FSM:
//   IDLE    -> LOAD on the first imem_we; -> DRAIN if loader_done is seen with no writes.
//   LOAD    -> DRAIN when loader_done=1. A write in the same cycle as loader_done is still accepted.
//   DRAIN   -> RELEASE on the cycle the FIFO is empty and no push is pending.
//              Writes arriving in DRAIN are still processed.
//   RELEASE -> held until reset. cpu_release=1 (registered, state-decoded).
//              Writes arriving in RELEASE are dropped and set addr_err.
// - loader_done dropping after DRAIN is entered has no effect.
// STRUCTURE
// - Shared package imem_ecc_pkg: CODE_W=39; parity position constants; typedef imem_code_t.
//   The IMEM decoder/checker reuses this package.
// - One sub-module: secded_enc_32 (combinational 32->39 encoder), instantiated once ahead of the FIFO.
// - FIFO and FSM are inline in this module.
// TESTING
// - Reset, then a write of addr 0x0 / data 0x00000000, mem_wready=1:
//   mem_we in the next cycle with idx 0 and code 39'h0; words_written=1.
// - Write of addr 0x4 / data 0x00000001: mem_widx=1, mem_wcode=39'h00_0000_000F.
// - Write of addr 0x2 and a write of addr DEPTH*4: both dropped; addr_err=1; words_written unchanged.
// - mem_wready=0, then 5 back-to-back writes (FIFO_DEPTH=4): 4 buffered, 5th dropped, ovf_err=1.
//   Raise mem_wready: 4 commits in order.
// - 3 writes, loader_done=1 with mem_wready=0 for 10 cycles: cpu_release stays 0.
//   cpu_release=1 exactly one cycle after the last pop; words_written=3.
// - rst=0 mid-DRAIN with 2 words buffered: all outputs 0 immediately.
//   After release, a fresh load completes normally.

Source files
------------

// File: rtl/imem_ecc_pkg.sv
// Shared SEC-DED definitions for the instruction memory: codeword layout, parity positions,
// and the loader-receiver FSM state type.
package imem_ecc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CODE_W  = 39;
  localparam int unsigned NUM_PAR = 6;

  typedef logic [CODE_W-1:0] imem_code_t;

  localparam logic [5:0] PAR_POS [NUM_PAR] = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StRelease
  } load_state_e;

  // Codeword position of data bit idx: the idx-th non-power-of-two position from 3 upwards.
  function automatic logic [5:0] data_pos(int unsigned idx);
    int unsigned cnt;
    cnt = 0;
    data_pos = '0;
    for (int unsigned p = 3; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) data_pos = 6'(p);
        cnt++;
      end
    end
  endfunction

  // Positions 1..38 whose index has bit j set, i.e. those covered by parity bit 2^j.
  function automatic imem_code_t cover_mask(int unsigned j);
    cover_mask = '0;
    for (int unsigned p = 1; p < CODE_W; p++) begin
      if (((p >> j) & 1) != 0) cover_mask[p] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/secded_enc_32.sv
// Combinational 32->39 SEC-DED encoder: Hamming(38,32) in bits 38:1, overall even parity in bit 0.
module secded_enc_32
  import imem_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output imem_code_t        code_o
);

  imem_code_t         data_bits;
  logic [NUM_PAR-1:0] par;

  always_comb begin
    data_bits = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_bits[data_pos(i)] = data_i[i];
    end
  end

  always_comb begin
    par = '0;
    for (int unsigned j = 0; j < NUM_PAR; j++) begin
      par[j] = ^(data_bits & cover_mask(j));
    end
  end

  always_comb begin
    code_o = data_bits;
    for (int unsigned j = 0; j < NUM_PAR; j++) begin
      code_o[PAR_POS[j]] = par[j];
    end
    code_o[0] = ^code_o[CODE_W-1:1];
  end

endmodule

// File: rtl/imem_load_receiver.sv
// Receives the loader write stream, validates and SEC-DED encodes each word, buffers it, and
// drives the IMEM write port; releases the CPU once every accepted word has committed.
module imem_load_receiver
  import imem_ecc_pkg::*;
#(
  parameter int unsigned AddrW     = 32,
  parameter int unsigned Depth     = 256,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned IdxW     = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             imem_we_i,
  input  logic [AddrW-1:0] imem_addr_i,
  input  logic [31:0]      imem_wdata_i,
  input  logic             loader_done_i,
  input  logic             mem_wready_i,
  output logic             mem_we_o,
  output logic [IdxW-1:0]  mem_widx_o,
  output imem_code_t       mem_wcode_o,
  output logic             cpu_release_o,
  output logic [15:0]      words_written_o,
  output logic             addr_err_o,
  output logic             ovf_err_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    imem_code_t      code;
  } entry_t;

  entry_t      fifo_q [FifoDepth];
  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  load_state_e state_q, state_d;
  logic [15:0] words_q, words_d;
  logic        addr_err_q, ovf_err_q;

  imem_code_t enc_code;
  logic       addr_ok, wr_ok, bad_wr, empty, full, pop, push, ovf;

  secded_enc_32 u_enc (
    .data_i (imem_wdata_i),
    .code_o (enc_code)
  );

  assign addr_ok = (imem_addr_i[1:0] == 2'b00) && ((imem_addr_i[AddrW-1:2] >> IdxW) == '0);
  assign wr_ok   = imem_we_i && addr_ok && (state_q != StRelease);
  assign bad_wr  = imem_we_i && !(addr_ok && (state_q != StRelease));

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop   = !empty && mem_wready_i;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign push  = wr_ok && (!full || pop);
  assign ovf   = wr_ok && full && !pop;

  assign wptr_d  = wptr_q + {{PtrW{1'b0}}, push};
  assign rptr_d  = rptr_q + {{PtrW{1'b0}}, pop};
  assign words_d = (pop && (words_q != 16'hFFFF)) ? words_q + 16'd1 : words_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (imem_we_i) begin
          state_d = StLoad;
        end else if (loader_done_i) begin
          state_d = StDrain;
        end
      end
      StLoad:    if (loader_done_i) state_d = StDrain;
      StDrain:   if (wptr_d == rptr_d) state_d = StRelease;
      StRelease: state_d = StRelease;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      words_q    <= '0;
      addr_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      words_q    <= words_d;
      addr_err_q <= addr_err_q | bad_wr;
      ovf_err_q  <= ovf_err_q | ovf;
    end
  end

  // Storage needs no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q[PtrW-1:0]] <= '{idx: imem_addr_i[IdxW+1:2], code: enc_code};
    end
  end

  assign mem_we_o        = !empty;
  assign mem_widx_o      = empty ? '0 : fifo_q[rptr_q[PtrW-1:0]].idx;
  assign mem_wcode_o     = empty ? '0 : fifo_q[rptr_q[PtrW-1:0]].code;
  assign cpu_release_o   = (state_q == StRelease);
  assign words_written_o = words_q;
  assign addr_err_o      = addr_err_q;
  assign ovf_err_o       = ovf_err_q;

endmodule
